// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions for the instruction-memory loader and the executor.
// Holds the loader mnemonic codes, opcode/funct constants, the default memory
// depth, the loader FSM state type and word-assembly helper functions.
package mips_isa_pkg;

    localparam int INSTR_NUM_DEF = 256;

    // Symbolic mnemonic codes presented on mnem_i; codes 10..15 are illegal.
    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_OR   = 4'd3,
        MN_SLT  = 4'd4,
        MN_ADDI = 4'd5,
        MN_LW   = 4'd6,
        MN_SW   = 4'd7,
        MN_SLTI = 4'd8,
        MN_BEQ  = 4'd9
    } mnem_e;

    // Primary opcodes as decoded by the executor.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // R-type function codes.
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    // Loader session states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

    // Assemble an R-type word; shamt is always zero for the supported set.
    function automatic logic [31:0] enc_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    // Assemble an I-type word.
    function automatic logic [31:0] enc_itype(input logic [5:0] op, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational MIPS instruction encoder.
// Ports:
//   mnem_i     mnemonic code (mips_isa_pkg::mnem_e values)
//   rs_i/rt_i/rd_i  register fields (rd_i ignored for I-type)
//   imm_i      signed immediate (BEQ: word offset)
//   ptr_i      word address the instruction will be written to
//   word_o     encoded 32-bit word (zero for illegal codes)
//   illegal_o  mnemonic code is not in the supported set
//   warn_o     word is legal but the executor will treat it as a no-op,
//              silently misalign, or ignore the branch
module mips_instr_encode
    import mips_isa_pkg::*;
#(
    parameter int INSTR_NUM = INSTR_NUM_DEF,
    parameter int ADDR_W    = 8
) (
    input  logic [3:0]        mnem_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [15:0]       imm_i,
    input  logic [ADDR_W-1:0] ptr_i,
    output logic [31:0]       word_o,
    output logic              illegal_o,
    output logic              warn_o
);

    // Wide enough that pointer + 1 + sext(imm) never wraps; a negative target
    // shows up as a huge unsigned value and fails the upper-bound compare.
    localparam int                TGT_W     = ADDR_W + 18;
    localparam logic [TGT_W-1:0]  TGT_LIMIT = TGT_W'(INSTR_NUM);

    logic [TGT_W-1:0] tgt_s;
    logic             tgt_bad_s;

    // Branch target range check relative to the slot being written.
    always_comb begin
        tgt_s     = {{18{1'b0}}, ptr_i}
                  + {{(TGT_W-1){1'b0}}, 1'b1}
                  + {{(TGT_W-16){imm_i[15]}}, imm_i};
        tgt_bad_s = tgt_s[TGT_W-1] | (tgt_s >= TGT_LIMIT);
    end

    // Mnemonic decode: word assembly plus illegal / executor-ignored flags.
    always_comb begin
        word_o    = 32'h0000_0000;
        illegal_o = 1'b0;
        warn_o    = 1'b0;
        case (mnem_i)
            MN_ADD: begin
                word_o = enc_rtype(rs_i, rt_i, rd_i, FN_ADD);
                warn_o = (rd_i == 5'd0);
            end
            MN_SUB: begin
                word_o = enc_rtype(rs_i, rt_i, rd_i, FN_SUB);
                warn_o = (rd_i == 5'd0);
            end
            MN_AND: begin
                word_o = enc_rtype(rs_i, rt_i, rd_i, FN_AND);
                warn_o = (rd_i == 5'd0);
            end
            MN_OR: begin
                word_o = enc_rtype(rs_i, rt_i, rd_i, FN_OR);
                warn_o = (rd_i == 5'd0);
            end
            MN_SLT: begin
                word_o = enc_rtype(rs_i, rt_i, rd_i, FN_SLT);
                warn_o = (rd_i == 5'd0);
            end
            MN_ADDI: begin
                word_o = enc_itype(OP_ADDI, rs_i, rt_i, imm_i);
                warn_o = (rt_i == 5'd0);
            end
            MN_LW: begin
                word_o = enc_itype(OP_LW, rs_i, rt_i, imm_i);
                warn_o = (rt_i == 5'd0) | (imm_i[1:0] != 2'b00);
            end
            MN_SW: begin
                word_o = enc_itype(OP_SW, rs_i, rt_i, imm_i);
                warn_o = (imm_i[1:0] != 2'b00);
            end
            MN_SLTI: begin
                word_o = enc_itype(OP_SLTI, rs_i, rt_i, imm_i);
            end
            MN_BEQ: begin
                word_o = enc_itype(OP_BEQ, rs_i, rt_i, imm_i);
                warn_o = tgt_bad_s;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: accepts symbolic instructions over a valid/ready
// handshake, encodes them and writes them to consecutive word addresses from 0.
// Ports:
//   clk_i, rst_i (async, active-low)
//   start_i            begin / restart a load session (clears pointer, count, flags)
//   in_valid_i/in_ready_o, last_i, mnem_i, rs_i, rt_i, rd_i, imm_i  instruction input
//   imem_we_o/imem_addr_o/imem_wdata_o  one-cycle write strobe to instruction memory
//   count_o            words written this session
//   busy_o, done_o     session status
//   err_o, warn_o      sticky illegal-mnemonic / executor-ignored-encoding flags
module instr_mem_loader
    import mips_isa_pkg::*;
#(
    parameter int INSTR_NUM = INSTR_NUM_DEF,
    parameter int ADDR_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              last_i,
    input  logic [3:0]        mnem_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [15:0]       imm_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              warn_o
);

    // Count value before the write that fills the memory.
    localparam logic [ADDR_W:0] COUNT_LAST = (ADDR_W+1)'(INSTR_NUM - 1);

    load_state_e       state_r;
    load_state_e       state_nxt_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic              err_r;
    logic              warn_r;

    logic [31:0]       word_s;
    logic              illegal_s;
    logic              enc_warn_s;
    logic              in_ready_s;
    logic              done_s;
    logic              busy_s;
    logic              accept_s;
    logic              write_s;

    mips_instr_encode #(
        .INSTR_NUM (INSTR_NUM),
        .ADDR_W    (ADDR_W)
    ) u_encode (
        .mnem_i    (mnem_i),
        .rs_i      (rs_i),
        .rt_i      (rt_i),
        .rd_i      (rd_i),
        .imm_i     (imm_i),
        .ptr_i     (ptr_r),
        .word_o    (word_s),
        .illegal_o (illegal_s),
        .warn_o    (enc_warn_s)
    );

    assign accept_s = in_valid_i & in_ready_s;
    // Illegal beats are consumed but never reach the memory.
    assign write_s  = accept_s & ~illegal_s;

    // Session state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start_i has priority over any handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (start_i) begin
                    state_nxt_s = ST_LOAD;
                end else if (accept_s && (last_i || (write_s && (count_r == COUNT_LAST)))) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; ready drops combinationally on a restart.
    always_comb begin
        in_ready_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_LOAD: begin
                in_ready_s = ~start_i;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
                done_s     = 1'b0;
            end
        endcase
        busy_s = (state_r == ST_LOAD) | we_r;
    end

    // Write pipeline, pointer, count and sticky flags; a pending write always
    // drains on the next cycle because we_r is only ever set by an accept.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_r   <= {ADDR_W{1'b0}};
            count_r <= {(ADDR_W+1){1'b0}};
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
            warn_r  <= 1'b0;
        end else if (start_i) begin
            ptr_r   <= {ADDR_W{1'b0}};
            count_r <= {(ADDR_W+1){1'b0}};
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            warn_r  <= 1'b0;
        end else begin
            we_r <= write_s;
            if (write_s) begin
                addr_r  <= ptr_r;
                wdata_r <= word_s;
                ptr_r   <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
            end
            if (accept_s && illegal_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            if (accept_s && enc_warn_s) begin
                warn_r <= 1'b1;
            end else begin
                warn_r <= warn_r;
            end
        end
    end

    assign in_ready_o   = in_ready_s;
    assign done_o       = done_s;
    assign busy_o       = busy_s;
    assign imem_we_o    = we_r;
    assign imem_addr_o  = addr_r;
    assign imem_wdata_o = wdata_r;
    assign count_o      = count_r;
    assign err_o        = err_r;
    assign warn_o       = warn_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table of single-instruction
// sessions plus hand-written multi-cycle sequences; memory writes are checked
// against a scoreboard queue filled when each beat is driven.
module tb_instr_mem_loader;
    import mips_isa_pkg::*;

    localparam int INSTR_NUM = 256;
    localparam int ADDR_W    = 8;

    logic              clk;
    logic              rst_i;
    logic              start_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              last_i;
    logic [3:0]        mnem_i;
    logic [4:0]        rs_i;
    logic [4:0]        rt_i;
    logic [4:0]        rd_i;
    logic [15:0]       imm_i;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;
    logic [ADDR_W:0]   count_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              warn_o;

    instr_mem_loader #(.INSTR_NUM(INSTR_NUM), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .last_i       (last_i),
        .mnem_i       (mnem_i),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .rd_i         (rd_i),
        .imm_i        (imm_i),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .count_o      (count_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .warn_o       (warn_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [3:0]  mn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic        ill;
        logic        warn;
        logic [31:0] data;
    } vec_t;

    wr_t  sb_q[$];
    vec_t vecs[17];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_ptr  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_i && imem_we_o) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, expected no write",
                         imem_addr_o, imem_wdata_o);
            end else begin
                wr_t w;
                w = sb_q.pop_front();
                chk("wr_addr", {24'd0, imem_addr_o}, {24'd0, w.addr});
                chk("wr_data", imem_wdata_o, w.data);
            end
        end
    end

    task automatic start_sess();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic beat(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last,
                        input logic exp_rdy, input logic exp_wr, input logic [31:0] exp_data,
                        input string name);
        mnem_i     = mn;
        rs_i       = rs;
        rt_i       = rt;
        rd_i       = rd;
        imm_i      = imm;
        last_i     = last;
        in_valid_i = 1'b1;
        #2;
        chk({name, "_ready"}, {31'd0, in_ready_o}, {31'd0, exp_rdy});
        if (exp_wr) begin
            sb_q.push_back('{addr: exp_ptr[ADDR_W-1:0], data: exp_data});
            exp_ptr++;
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        last_i     = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 6; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk({name, "_drain"}, sb_q.size(), 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_we"},    {31'd0, imem_we_o},  32'd0);
        chk({name, "_addr"},  {24'd0, imem_addr_o}, 32'd0);
        chk({name, "_wdata"}, imem_wdata_o,        32'd0);
        chk({name, "_count"}, {23'd0, count_o},    32'd0);
        chk({name, "_busy"},  {31'd0, busy_o},     32'd0);
        chk({name, "_done"},  {31'd0, done_o},     32'd0);
        chk({name, "_err"},   {31'd0, err_o},      32'd0);
        chk({name, "_warn"},  {31'd0, warn_o},     32'd0);
        chk({name, "_ready"}, {31'd0, in_ready_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          mn     rs     rt     rd     imm       ill   warn  data
        vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 1'b0, 1'b0, 32'h00221820};
        vecs[1]  = '{4'd5,  5'd0,  5'd1,  5'd0,  16'h0005, 1'b0, 1'b0, 32'h20010005};
        vecs[2]  = '{4'd6,  5'd0,  5'd2,  5'd0,  16'h0004, 1'b0, 1'b0, 32'h8C020004};
        vecs[3]  = '{4'd9,  5'd1,  5'd2,  5'd0,  16'hFFFF, 1'b0, 1'b0, 32'h1022FFFF};
        vecs[4]  = '{4'd9,  5'd1,  5'd2,  5'd0,  16'hFFFE, 1'b0, 1'b1, 32'h1022FFFE};
        vecs[5]  = '{4'd7,  5'd0,  5'd3,  5'd7,  16'h0002, 1'b0, 1'b1, 32'hAC030002};
        vecs[6]  = '{4'd12, 5'd1,  5'd2,  5'd3,  16'h0000, 1'b1, 1'b0, 32'h00000000};
        vecs[7]  = '{4'd1,  5'd4,  5'd5,  5'd0,  16'h0000, 1'b0, 1'b1, 32'h00850022};
        vecs[8]  = '{4'd8,  5'd6,  5'd7,  5'd0,  16'h8000, 1'b0, 1'b0, 32'h28C78000};
        vecs[9]  = '{4'd9,  5'd1,  5'd2,  5'd0,  16'h00FE, 1'b0, 1'b0, 32'h102200FE};
        vecs[10] = '{4'd9,  5'd1,  5'd2,  5'd0,  16'h00FF, 1'b0, 1'b1, 32'h102200FF};
        vecs[11] = '{4'd3,  5'd31, 5'd31, 5'd31, 16'h0000, 1'b0, 1'b0, 32'h03FFF825};
        vecs[12] = '{4'd6,  5'd0,  5'd0,  5'd0,  16'h0008, 1'b0, 1'b1, 32'h8C000008};
        vecs[13] = '{4'd2,  5'd2,  5'd3,  5'd1,  16'h0000, 1'b0, 1'b0, 32'h00430824};
        vecs[14] = '{4'd4,  5'd1,  5'd2,  5'd9,  16'h0000, 1'b0, 1'b0, 32'h0022482A};
        vecs[15] = '{4'd15, 5'd1,  5'd1,  5'd1,  16'h1234, 1'b1, 1'b0, 32'h00000000};
        vecs[16] = '{4'd5,  5'd3,  5'd0,  5'd0,  16'hFFFF, 1'b0, 1'b1, 32'h2060FFFF};

        rst_i      = 1'b0;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        last_i     = 1'b0;
        mnem_i     = 4'd0;
        rs_i       = 5'd0;
        rt_i       = 5'd0;
        rd_i       = 5'd0;
        imm_i      = 16'h0000;
        #12;
        chk_all_zero("reset");
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("idle");

        // One-instruction sessions from the table.
        for (int i = 0; i < 17; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            start_sess();
            chk({nm, "_busy_load"}, {31'd0, busy_o}, 32'd1);
            beat(vecs[i].mn, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, 1'b1,
                 1'b1, ~vecs[i].ill, vecs[i].data, nm);
            drain(nm);
            chk({nm, "_done"},  {31'd0, done_o},     32'd1);
            chk({nm, "_err"},   {31'd0, err_o},      {31'd0, vecs[i].ill});
            chk({nm, "_warn"},  {31'd0, warn_o},     {31'd0, vecs[i].warn});
            chk({nm, "_count"}, {23'd0, count_o},    vecs[i].ill ? 32'd0 : 32'd1);
            chk({nm, "_ready"}, {31'd0, in_ready_o}, 32'd0);
            chk({nm, "_busy"},  {31'd0, busy_o},     32'd0);
        end

        // Back-to-back ADDI then LW with last.
        start_sess();
        beat(MN_ADDI, 5'd0, 5'd1, 5'd0, 16'h0005, 1'b0, 1'b1, 1'b1, 32'h20010005, "b2b0");
        chk("b2b0_we", {31'd0, imem_we_o}, 32'd1);
        beat(MN_LW, 5'd0, 5'd2, 5'd0, 16'h0004, 1'b1, 1'b1, 1'b1, 32'h8C020004, "b2b1");
        chk("b2b1_we",    {31'd0, imem_we_o},  32'd1);
        chk("b2b1_done",  {31'd0, done_o},     32'd1);
        chk("b2b1_ready", {31'd0, in_ready_o}, 32'd0);
        chk("b2b1_busy",  {31'd0, busy_o},     32'd1);
        drain("b2b");
        chk("b2b_count", {23'd0, count_o}, 32'd2);

        // Illegal mnemonic mid-program: consumed, no write, pointer held.
        start_sess();
        beat(MN_ADD, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h00221820, "ill0");
        beat(4'd12, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0, "ill1");
        chk("ill1_we", {31'd0, imem_we_o}, 32'd0);
        beat(MN_ADDI, 5'd0, 5'd1, 5'd0, 16'h0005, 1'b1, 1'b1, 1'b1, 32'h20010005, "ill2");
        drain("ill");
        chk("ill_count", {23'd0, count_o}, 32'd2);
        chk("ill_err",   {31'd0, err_o},   32'd1);
        chk("ill_warn",  {31'd0, warn_o},  32'd0);

        // Fill the whole memory without last_i.
        start_sess();
        for (int i = 0; i < INSTR_NUM; i++) begin
            beat(MN_ADD, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h00221820, "fill");
        end
        chk("fill_done",  {31'd0, done_o},  32'd1);
        chk("fill_count", {23'd0, count_o}, 32'd256);
        for (int i = 0; i < 3; i++) begin
            beat(MN_ADD, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, "full");
        end
        drain("fill");
        chk("full_count", {23'd0, count_o},    32'd256);
        chk("full_ready", {31'd0, in_ready_o}, 32'd0);
        chk("full_done",  {31'd0, done_o},     32'd1);

        // start_i together with in_valid_i in LOAD: no accept, pointer restarts.
        start_sess();
        beat(MN_ADD, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h00221820, "rs0");
        beat(MN_SUB, 5'd4, 5'd5, 5'd6, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h00853022, "rs1");
        start_i    = 1'b1;
        in_valid_i = 1'b1;
        mnem_i     = MN_OR;
        #2;
        chk("rs_start_ready", {31'd0, in_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        in_valid_i = 1'b0;
        exp_ptr    = 0;
        chk("rs_count_clr", {23'd0, count_o}, 32'd0);
        beat(MN_AND, 5'd2, 5'd3, 5'd1, 16'h0000, 1'b1, 1'b1, 1'b1, 32'h00430824, "rs2");
        drain("rs");
        chk("rs_count", {23'd0, count_o}, 32'd1);

        // Asynchronous reset while a write is pending.
        start_sess();
        beat(MN_ADD, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h00221820, "rst0");
        chk("rst_pending_we", {31'd0, imem_we_o}, 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        chk_all_zero("midrst");
        sb_q.delete();
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("postrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
